cube_color_tracker: RTL and testbench
=====================================

Name: cube_color_tracker

Overview:
- Owns the per-cube colour state of the 28-cube pyramid.
- Watches the Q*bert landing handshake (done_move) and the one-hot landing box (position_qb) produced by the map/colour renderer, and updates the colour bit of the landed cube according to the level's colour rule.
- Its registered colour vector drives the renderer's e_color_state input directly. It also reports progress and level completion to the NIOS.

Parameters:
- N_CUBE, 28, number of cubes (width of position_qb / color_state).
- CNT_W, 5, width of colored-cube counter.
- SAMPLE_DLY, 2, cycles from done_move rising edge to position_qb sample (covers monster_position register pipeline).

Ports:
- CLK_33  in  1  pixel/system clock.
- reset  in  1  synchronous, active-high.
- e_start_qb  in  1  level start; clears board (level-sensitive, highest priority after reset).
- e_pause_qb  in  1  while high, landings are ignored.
- e_color_mode  in  2  0=SET, 1=TOGGLE, 2=TWO_HIT, 3=reserved (treated as SET).
- done_move  in  1  Q*bert landing strobe, level signal; only its rising edge is used.
- position_qb  in  N_CUBE  one-hot landed-cube box; all-zero = off map.
- color_state  out  N_CUBE  bit=1 cube at target colour; feeds e_color_state.
- n_colored  out  CNT_W  number of set bits in color_state.
- win_level  out  1  sticky: all cubes at target; cleared by e_start_qb/reset.
- win_pulse  out  1  one-cycle pulse when win_level rises.
- off_map  out  1  one-cycle pulse: sample found position_qb==0.
- pos_err  out  1  one-cycle pulse: sample found >1 bit set.
- fsm_state  out  2  IDLE=0, WAIT=1, UPDATE=2, WIN=3 (debug/NIOS).

Behaviour:
- Reset: color_state=0, hit_half (internal N_CUBE vector)=0, n_colored=0, win_level=0, win_pulse=0, off_map=0, pos_err=0, fsm_state=IDLE, done_q=0.
- Edge detect: done_q registers done_move every cycle. rise = done_move & ~done_q.
- IDLE:
  - If rise & ~e_pause_qb at cycle t: load dly_cnt=SAMPLE_DLY-1 and go to WAIT.
  - Any other rise is discarded. It is not queued.
- WAIT:
  - Decrement dly_cnt each cycle.
  - When dly_cnt==0, latch pos_s<=position_qb at cycle t+SAMPLE_DLY and go to UPDATE.
  - Any rise seen in WAIT is ignored.
  - If e_pause_qb rises during WAIT, abort to IDLE with no update.
- UPDATE (one cycle):
  - If pos_s==0: pulse off_map, no change.
  - Else if popcount(pos_s)>1: pulse pos_err, no change.
  - Else, for index k:
    - SET: color_state[k]<=1.
    - TOGGLE: color_state[k]<=~color_state[k].
    - TWO_HIT:
      - If hit_half[k]=0 and color_state[k]=0: hit_half[k]<=1.
      - Else if hit_half[k]=1: hit_half[k]<=0 and color_state[k]<=1.
      - Already-set cubes stay set.
  - n_colored updates in the same cycle: +1 on a 0->1 transition, -1 on 1->0, else hold. It never wraps; N_CUBE≤2^CNT_W-1 is required.
  - The new color_state/n_colored are visible at t+SAMPLE_DLY+1.
  - Next state is WIN if the next n_colored==N_CUBE, else IDLE.
- WIN:
  - Entered with win_level<=1 and win_pulse<=1 for exactly the entry cycle, i.e. win_pulse high at t+SAMPLE_DLY+1.
  - All landings are ignored.
  - Stays in WIN until e_start_qb.
- e_start_qb (any state, any cycle):
  - Next cycle color_state=0, hit_half=0, n_colored=0, win_level=0, state=IDLE.
  - Aborts a pending WAIT/UPDATE. A rise coincident with start is dropped.
- Mode change mid-level: takes effect at the next UPDATE. hit_half is retained but only consulted in TWO_HIT.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Shared package qbert_pkg:
  - typedef enum logic[1:0] {CM_SET, CM_TOGGLE, CM_TWO_HIT} color_mode_t.
  - typedef enum logic[1:0] {CT_IDLE, CT_WAIT, CT_UPDATE, CT_WIN} ct_state_t.
  - localparam N_CUBE=28.
- One sub-module, onehot_decode: N_CUBE one-hot -> index[4:0] + zero + multi flags, purely combinational. It is reusable by the monster logic.

Test Plan:
- Reset then SET mode; done_move 0->1 with position_qb=28'h0000001 -> color_state=28'h1 and n_colored=1 at edge+3 cycles; second landing on same cube -> unchanged, n_colored=1.
- TOGGLE mode, three landings on bit 5 -> color_state[5] = 1,0,1; n_colored = 1,0,1.
- TWO_HIT mode, two landings on bit 27 -> after first color_state=0; after second color_state[27]=1, n_colored=1.
- SET mode, land on all 28 cubes in sequence -> on 28th, n_colored=28, win_pulse high one cycle, win_level=1, fsm_state=3; further landing ignored; e_start_qb -> all zero, IDLE next cycle.
- position_qb=0 at sample -> off_map one-cycle pulse, no state change; position_qb=28'h0000003 -> pos_err pulse, no change.
- done_move rise, then e_pause_qb asserted 1 cycle later (in WAIT) -> no update, IDLE; rise during pause -> ignored; e_start_qb asserted in WAIT -> cleared, no update.

Source files
------------

// File: rtl/qbert_pkg.sv
// Shared Q*bert types and board constants.
// Used by the colour tracker and the monster logic.
package qbert_pkg;

  localparam int N_CUBE     = 28;
  localparam int CNT_W      = 5;
  localparam int SAMPLE_DLY = 2;
  localparam int IDX_W      = $clog2(N_CUBE);
  localparam int DLY_W      = 2;

  typedef enum logic [1:0] {
    CM_SET,
    CM_TOGGLE,
    CM_TWO_HIT
  } color_mode_t;

  typedef enum logic [1:0] {
    CT_IDLE,
    CT_WAIT,
    CT_UPDATE,
    CT_WIN
  } ct_state_t;

endpackage

// File: rtl/cube_color_tracker_onehot_decode.sv
// One-hot box vector to cube index, with empty and multi-hit flags.
// Purely combinational so it can be shared with the monster logic.
module onehot_decode
  import qbert_pkg::*;
(
  input  logic [N_CUBE-1:0] i_vec,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_zero,
  output logic              o_multi
);

  logic w_seen;

  always_comb begin
    o_idx   = '0;
    o_multi = 1'b0;
    w_seen  = 1'b0;
    for (int i = 0; i < N_CUBE; i++) begin
      if (i_vec[i]) begin
        o_idx   = o_idx | IDX_W'(i);
        o_multi = o_multi | w_seen;
        w_seen  = 1'b1;
      end
    end
    o_zero = ~w_seen;
  end

endmodule

// File: rtl/cube_color_tracker.sv
// Per-cube colour state of the pyramid, updated on each Q*bert landing.
// Drives the renderer colour vector and reports progress / level win.
module cube_color_tracker
  import qbert_pkg::*;
(
  input  logic              CLK_33,
  input  logic              reset,
  input  logic              e_start_qb,
  input  logic              e_pause_qb,
  input  logic [1:0]        e_color_mode,
  input  logic              done_move,
  input  logic [N_CUBE-1:0] position_qb,
  output logic [N_CUBE-1:0] color_state,
  output logic [CNT_W-1:0]  n_colored,
  output logic              win_level,
  output logic              win_pulse,
  output logic              off_map,
  output logic              pos_err,
  output logic [1:0]        fsm_state
);

  ct_state_t         r_state;
  logic [DLY_W-1:0]  r_dly;
  logic [N_CUBE-1:0] r_pos_s;
  logic [N_CUBE-1:0] r_color;
  logic [N_CUBE-1:0] r_hit;
  logic [CNT_W-1:0]  r_n;
  logic              r_done_q;
  logic              r_win;
  logic              r_win_pulse;
  logic              r_off_map;
  logic              r_pos_err;

  logic              w_rise;
  logic [IDX_W-1:0]  w_idx;
  logic              w_zero;
  logic              w_multi;
  logic              w_old;
  logic              w_new;
  logic [N_CUBE-1:0] w_color_nxt;
  logic [N_CUBE-1:0] w_hit_nxt;
  logic [CNT_W-1:0]  w_n_nxt;

  assign w_rise = done_move & ~r_done_q;

  onehot_decode u_dec (
    .i_vec   (r_pos_s),
    .o_idx   (w_idx),
    .o_zero  (w_zero),
    .o_multi (w_multi)
  );

  // Next colour/half-hit state for the landed cube under the current rule.
  always_comb begin
    w_color_nxt = r_color;
    w_hit_nxt   = r_hit;
    w_old       = r_color[w_idx];
    w_new       = w_old;
    case (color_mode_t'(e_color_mode))
      CM_TOGGLE: w_new = ~w_old;
      CM_TWO_HIT: begin
        if (!r_hit[w_idx] && !w_old) begin
          w_hit_nxt[w_idx] = 1'b1;
        end else if (r_hit[w_idx]) begin
          w_hit_nxt[w_idx] = 1'b0;
          w_new            = 1'b1;
        end
      end
      default: w_new = 1'b1;
    endcase
    w_color_nxt[w_idx] = w_new;
    if (w_new && !w_old)      w_n_nxt = r_n + 1'b1;
    else if (!w_new && w_old) w_n_nxt = r_n - 1'b1;
    else                      w_n_nxt = r_n;
  end

  always_ff @(posedge CLK_33) begin
    r_done_q    <= reset ? 1'b0 : done_move;
    r_win_pulse <= 1'b0;
    r_off_map   <= 1'b0;
    r_pos_err   <= 1'b0;
    if (reset || e_start_qb) begin
      r_state <= CT_IDLE;
      r_dly   <= '0;
      r_pos_s <= '0;
      r_color <= '0;
      r_hit   <= '0;
      r_n     <= '0;
      r_win   <= 1'b0;
    end else begin
      unique case (r_state)
        CT_IDLE: begin
          if (w_rise && !e_pause_qb) begin
            r_dly   <= DLY_W'(SAMPLE_DLY - 1);
            r_state <= CT_WAIT;
          end
        end
        CT_WAIT: begin
          if (e_pause_qb) begin
            r_state <= CT_IDLE;
          end else if (r_dly == '0) begin
            r_pos_s <= position_qb;
            r_state <= CT_UPDATE;
          end else begin
            r_dly <= r_dly - 1'b1;
          end
        end
        CT_UPDATE: begin
          r_state <= CT_IDLE;
          if (w_zero) begin
            r_off_map <= 1'b1;
          end else if (w_multi) begin
            r_pos_err <= 1'b1;
          end else begin
            r_color <= w_color_nxt;
            r_hit   <= w_hit_nxt;
            r_n     <= w_n_nxt;
            if (w_n_nxt == CNT_W'(N_CUBE)) begin
              r_win       <= 1'b1;
              r_win_pulse <= 1'b1;
              r_state     <= CT_WIN;
            end
          end
        end
        CT_WIN: r_state <= CT_WIN;
      endcase
    end
  end

  assign color_state = r_color;
  assign n_colored   = r_n;
  assign win_level   = r_win;
  assign win_pulse   = r_win_pulse;
  assign off_map     = r_off_map;
  assign pos_err     = r_pos_err;
  assign fsm_state   = r_state;

endmodule

// File: tb/tb_cube_color_tracker.sv
// Directed self-checking bench for cube_color_tracker.
// Each task drives one scenario and checks hand-computed values.
module tb_cube_color_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_start_qb;
  logic        e_pause_qb;
  logic [1:0]  e_color_mode;
  logic        done_move;
  logic [27:0] position_qb;
  logic [27:0] color_state;
  logic [4:0]  n_colored;
  logic        win_level;
  logic        win_pulse;
  logic        off_map;
  logic        pos_err;
  logic [1:0]  fsm_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cube_color_tracker dut (
    .CLK_33       (clk),
    .reset        (reset),
    .e_start_qb   (e_start_qb),
    .e_pause_qb   (e_pause_qb),
    .e_color_mode (e_color_mode),
    .done_move    (done_move),
    .position_qb  (position_qb),
    .color_state  (color_state),
    .n_colored    (n_colored),
    .win_level    (win_level),
    .win_pulse    (win_pulse),
    .off_map      (off_map),
    .pos_err      (pos_err),
    .fsm_state    (fsm_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rise at edge t, sample at t+2, result visible after edge t+3.
  task automatic land(input logic [27:0] pos);
    done_move   = 1'b1;
    position_qb = pos;
    tick();
    done_move = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic do_start();
    e_start_qb = 1'b1;
    tick();
    e_start_qb = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (color_state !== 28'h0) begin
      $display("FAIL reset_color got=%h exp=%h", color_state, 28'h0);
      failures++;
    end
    checks++;
    if (n_colored !== 5'd0 || win_level !== 1'b0 || win_pulse !== 1'b0) begin
      $display("FAIL reset_cnt got=%0d/%b/%b exp=0/0/0", n_colored, win_level, win_pulse);
      failures++;
    end
    checks++;
    if (fsm_state !== 2'd0 || off_map !== 1'b0 || pos_err !== 1'b0) begin
      $display("FAIL reset_state got=%0d/%b/%b exp=0/0/0", fsm_state, off_map, pos_err);
      failures++;
    end
  endtask

  task automatic test_set();
    e_color_mode = 2'd0;
    land(28'h0000001);
    checks++;
    if (color_state !== 28'h1 || n_colored !== 5'd1) begin
      $display("FAIL set_first got=%h/%0d exp=%h/1", color_state, n_colored, 28'h1);
      failures++;
    end
    land(28'h0000001);
    checks++;
    if (color_state !== 28'h1 || n_colored !== 5'd1) begin
      $display("FAIL set_again got=%h/%0d exp=%h/1", color_state, n_colored, 28'h1);
      failures++;
    end
  endtask

  task automatic test_toggle();
    logic [27:0] exp_c [3] = '{28'h20, 28'h0, 28'h20};
    logic [4:0]  exp_n [3] = '{5'd1, 5'd0, 5'd1};
    do_start();
    e_color_mode = 2'd1;
    for (int i = 0; i < 3; i++) begin
      land(28'h20);
      checks++;
      if (color_state !== exp_c[i] || n_colored !== exp_n[i]) begin
        $display("FAIL toggle_%0d got=%h/%0d exp=%h/%0d", i, color_state, n_colored, exp_c[i], exp_n[i]);
        failures++;
      end
    end
  endtask

  task automatic test_two_hit();
    do_start();
    e_color_mode = 2'd2;
    land(28'h8000000);
    checks++;
    if (color_state !== 28'h0 || n_colored !== 5'd0) begin
      $display("FAIL twohit_1 got=%h/%0d exp=%h/0", color_state, n_colored, 28'h0);
      failures++;
    end
    land(28'h8000000);
    checks++;
    if (color_state !== 28'h8000000 || n_colored !== 5'd1) begin
      $display("FAIL twohit_2 got=%h/%0d exp=%h/1", color_state, n_colored, 28'h8000000);
      failures++;
    end
  endtask

  task automatic test_win();
    logic [27:0] pos;
    do_start();
    e_color_mode = 2'd0;
    for (int i = 0; i < 27; i++) begin
      pos = 28'h1 << i;
      land(pos);
    end
    checks++;
    if (n_colored !== 5'd27 || win_level !== 1'b0 || fsm_state !== 2'd0) begin
      $display("FAIL win_pre got=%0d/%b/%0d exp=27/0/0", n_colored, win_level, fsm_state);
      failures++;
    end
    land(28'h8000000);
    checks++;
    if (n_colored !== 5'd28 || color_state !== 28'hFFFFFFF) begin
      $display("FAIL win_count got=%0d/%h exp=28/%h", n_colored, color_state, 28'hFFFFFFF);
      failures++;
    end
    checks++;
    if (win_pulse !== 1'b1 || win_level !== 1'b1 || fsm_state !== 2'd3) begin
      $display("FAIL win_entry got=%b/%b/%0d exp=1/1/3", win_pulse, win_level, fsm_state);
      failures++;
    end
    tick();
    checks++;
    if (win_pulse !== 1'b0 || win_level !== 1'b1) begin
      $display("FAIL win_pulse_len got=%b/%b exp=0/1", win_pulse, win_level);
      failures++;
    end
    e_color_mode = 2'd1;
    land(28'h1);
    checks++;
    if (color_state !== 28'hFFFFFFF || fsm_state !== 2'd3 || win_pulse !== 1'b0) begin
      $display("FAIL win_ignore got=%h/%0d/%b exp=%h/3/0", color_state, fsm_state, win_pulse, 28'hFFFFFFF);
      failures++;
    end
    do_start();
    checks++;
    if (color_state !== 28'h0 || n_colored !== 5'd0 || win_level !== 1'b0 || fsm_state !== 2'd0) begin
      $display("FAIL win_start got=%h/%0d/%b/%0d exp=0/0/0/0", color_state, n_colored, win_level, fsm_state);
      failures++;
    end
  endtask

  task automatic test_errors();
    do_start();
    e_color_mode = 2'd0;
    land(28'h0);
    checks++;
    if (off_map !== 1'b1 || pos_err !== 1'b0 || color_state !== 28'h0) begin
      $display("FAIL offmap got=%b/%b/%h exp=1/0/0", off_map, pos_err, color_state);
      failures++;
    end
    tick();
    checks++;
    if (off_map !== 1'b0) begin
      $display("FAIL offmap_len got=%b exp=0", off_map);
      failures++;
    end
    land(28'h3);
    checks++;
    if (pos_err !== 1'b1 || off_map !== 1'b0 || color_state !== 28'h0 || n_colored !== 5'd0) begin
      $display("FAIL poserr got=%b/%b/%h/%0d exp=1/0/0/0", pos_err, off_map, color_state, n_colored);
      failures++;
    end
    tick();
    checks++;
    if (pos_err !== 1'b0) begin
      $display("FAIL poserr_len got=%b exp=0", pos_err);
      failures++;
    end
  endtask

  task automatic test_pause_start();
    do_start();
    e_color_mode = 2'd0;
    done_move   = 1'b1;
    position_qb = 28'h4;
    tick();
    checks++;
    if (fsm_state !== 2'd1) begin
      $display("FAIL wait_state got=%0d exp=1", fsm_state);
      failures++;
    end
    done_move  = 1'b0;
    e_pause_qb = 1'b1;
    tick();
    e_pause_qb = 1'b0;
    tick();
    tick();
    checks++;
    if (fsm_state !== 2'd0 || color_state !== 28'h0) begin
      $display("FAIL pause_abort got=%0d/%h exp=0/0", fsm_state, color_state);
      failures++;
    end
    e_pause_qb  = 1'b1;
    done_move   = 1'b1;
    position_qb = 28'h8;
    tick();
    done_move = 1'b0;
    tick();
    tick();
    tick();
    e_pause_qb = 1'b0;
    checks++;
    if (fsm_state !== 2'd0 || color_state !== 28'h0) begin
      $display("FAIL pause_rise got=%0d/%h exp=0/0", fsm_state, color_state);
      failures++;
    end
    done_move   = 1'b1;
    position_qb = 28'h10;
    tick();
    done_move  = 1'b0;
    e_start_qb = 1'b1;
    tick();
    e_start_qb = 1'b0;
    checks++;
    if (fsm_state !== 2'd0) begin
      $display("FAIL start_wait got=%0d exp=0", fsm_state);
      failures++;
    end
    tick();
    tick();
    checks++;
    if (color_state !== 28'h0 || n_colored !== 5'd0) begin
      $display("FAIL start_noupd got=%h/%0d exp=0/0", color_state, n_colored);
      failures++;
    end
    land(28'h40);
    checks++;
    if (color_state !== 28'h40 || n_colored !== 5'd1) begin
      $display("FAIL post_pause got=%h/%0d exp=%h/1", color_state, n_colored, 28'h40);
      failures++;
    end
  endtask

  initial begin
    reset        = 1'b1;
    e_start_qb   = 1'b0;
    e_pause_qb   = 1'b0;
    e_color_mode = 2'd0;
    done_move    = 1'b0;
    position_qb  = 28'h0;
    test_reset();
    test_set();
    test_toggle();
    test_two_hit();
    test_win();
    test_errors();
    test_pause_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
